psram_line_fetch: RTL and testbench

Video line-fetch DMA engine in the PSRAM controller clock domain (mclk_out).
- On a line-start request it reads one full scanline (64 blocks × 4 beats × 64 bit = 1024 RGB565 pixels) from PSRAM.
- It writes the data into port A of the 256x64 line buffer that the LCD timing stage reads.
- It does not own the PSRAM command port: it requests it from the PSRAM arbiter with a req/gnt handshake, and the CPU bus path competes there.

---
 rtl/psram_line_fetch.sv | 121 ++++++++++++
 tb/tb_psram_line_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_line_fetch.sv
// Scanline fetch DMA: arbitrates for the PSRAM command port one 4-beat burst at a time
// and streams the returned beats into port A of the 256x64 line buffer.
module psram_line_fetch #(
    parameter int BLOCKS_PER_LINE = 64,
    parameter int BEATS_PER_BLOCK = 4,
    parameter int LINE_W          = 10,
    parameter int TIMEOUT_CYC     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [LINE_W-1:0] line_num,
    output logic              busy,
    output logic              line_done,
    output logic              line_err,
    output logic              overrun,
    output logic              psram_req,
    input  logic              psram_gnt,
    output logic              cmd,
    output logic              cmd_en,
    output logic [20:0]       addr,
    output logic [7:0]        data_mask,
    input  logic [63:0]       rd_data,
    input  logic              rd_data_valid,
    output logic              lb_we,
    output logic [7:0]        lb_waddr,
    output logic [63:0]       lb_wdata
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, REQ, CMD, DATA, NEXT} state_t;

    state_t            state;
    logic [LINE_W-1:0] line;
    logic [5:0]        blk;
    logic [1:0]        beat;
    logic [TW-1:0]     timer;
    logic [LINE_W+8:0] line_addr;

    assign line_addr = {line, blk, 3'b000};
    // busy drops one cycle early on the last block / timeout, so the port is released
    // in the same cycle that line_done is shown.
    assign psram_req = busy && (state == REQ || state == CMD || state == DATA);
    assign cmd       = 1'b0;
    assign data_mask = 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line      <= '0;
            blk       <= '0;
            beat      <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            line_done <= 1'b0;
            line_err  <= 1'b0;
            overrun   <= 1'b0;
            cmd_en    <= 1'b0;
            addr      <= '0;
            lb_we     <= 1'b0;
            lb_waddr  <= '0;
            lb_wdata  <= '0;
        end else begin
            line_done <= 1'b0;
            line_err  <= 1'b0;
            overrun   <= 1'b0;
            cmd_en    <= 1'b0;
            lb_we     <= 1'b0;
            if (line_start && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (line_start) begin
                    line  <= line_num;
                    blk   <= '0;
                    busy  <= 1'b1;
                    state <= REQ;
                end
                REQ: if (psram_gnt) begin
                    addr   <= 21'(line_addr);
                    cmd_en <= 1'b1;
                    state  <= CMD;
                end
                CMD: begin
                    beat  <= '0;
                    timer <= '0;
                    state <= DATA;
                end
                DATA: begin
                    // !busy here means the timeout was flagged last cycle: leave, ignore beats
                    if (!busy) begin
                        state <= IDLE;
                    end else if (rd_data_valid) begin
                        lb_we    <= 1'b1;
                        lb_wdata <= rd_data;
                        lb_waddr <= {blk, beat};
                        beat     <= beat + 2'd1;
                        timer    <= '0;
                        if (beat == 2'(BEATS_PER_BLOCK - 1)) begin
                            state <= NEXT;
                            if (blk == 6'(BLOCKS_PER_LINE - 1)) begin
                                line_done <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
                    end else if (timer == TW'(TIMEOUT_CYC - 2)) begin
                        line_done <= 1'b1;
                        line_err  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                NEXT: begin
                    blk   <= blk + 6'd1;
                    state <= busy ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_line_fetch.sv
// Directed/randomised bench for psram_line_fetch with an arbiter + PSRAM model and a
// reference of the expected line-buffer image (k-th write of a line lands at k).
`timescale 1ns/1ps
module tb_psram_line_fetch;
    localparam int TO = 255;

    logic        clk = 1'b0, reset = 1'b1, line_start = 1'b0;
    logic [9:0]  line_num = '0;
    logic        busy, line_done, line_err, overrun, psram_req, cmd, cmd_en, lb_we;
    logic        psram_gnt = 1'b0, rd_data_valid = 1'b0;
    logic [63:0] rd_data = '0;
    logic [20:0] addr;
    logic [7:0]  data_mask, lb_waddr;
    logic [63:0] lb_wdata;

    psram_line_fetch dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
        .busy(busy), .line_done(line_done), .line_err(line_err), .overrun(overrun),
        .psram_req(psram_req), .psram_gnt(psram_gnt), .cmd(cmd), .cmd_en(cmd_en),
        .addr(addr), .data_mask(data_mask), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .lb_we(lb_we), .lb_waddr(lb_waddr),
        .lb_wdata(lb_wdata)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, nwr = 0, ncmd = 0, ndone = 0, nerr = 0, novr = 0, req_low = 0;
    int cur_line = 0, mcmd = 0, drop_blk = -1, t2 = 0, done_cyc = 0;
    int gnt_min = 0, gnt_max = 0;
    logic [63:0] seed;
    logic [63:0] lb_img [256];
    logic [63:0] ref_img [256];

    function automatic logic [63:0] mem_word(input logic [20:0] a);
        return ({43'd0, a} * 64'h9E3779B97F4A7C15) ^ seed;
    endfunction

    function automatic logic [63:0] exp_data(input int ln, input int k);
        return mem_word(21'(ln * 512 + (k / 4) * 8 + (k % 4)));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Arbiter: grants after a random delay, drops grant once req is released.
    initial begin
        int gwait;
        gwait = -1;
        forever begin
            @(negedge clk);
            if (!psram_req) begin
                psram_gnt = 1'b0;
                gwait = -1;
            end else if (!psram_gnt) begin
                if (gwait < 0) gwait = $urandom_range(gnt_max, gnt_min);
                if (gwait == 0) psram_gnt = 1'b1;
                else gwait--;
            end
        end
    end

    // PSRAM: 4 beats starting 8 cycles after each cmd_en; optionally drops beats 3..4 of one block.
    initial begin
        logic [20:0] a;
        int b;
        forever begin
            @(negedge clk);
            if (cmd_en) begin
                a = addr;
                b = mcmd;
                mcmd++;
                repeat (7) @(negedge clk);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    if (b == drop_blk && j >= 2) begin
                        rd_data_valid = 1'b0;
                    end else begin
                        rd_data_valid = 1'b1;
                        rd_data = mem_word(a + 21'(j));
                        if (b == drop_blk && j == 1) t2 = cyc;
                    end
                end
                @(negedge clk);
                rd_data_valid = 1'b0;
            end
        end
    end

    // Output monitor: every write, command and pulse is checked against the reference.
    initial forever begin
        @(negedge clk);
        if (lb_we) begin
            chk("lb_waddr", 64'(lb_waddr), 64'(nwr[7:0]));
            chk("lb_wdata", lb_wdata, exp_data(cur_line, nwr));
            lb_img[lb_waddr] = lb_wdata;
            nwr++;
        end
        if (cmd_en) begin
            chk("cmd_addr", 64'(addr), 64'(21'(cur_line * 512 + ncmd * 8)));
            chk("cmd_gnt", 64'(psram_gnt), 64'd1);
            chk("cmd_rd", 64'(cmd), 64'd0);
            ncmd++;
        end
        if (line_done) begin
            ndone++;
            done_cyc = cyc;
            chk("busy_at_done", 64'(busy), 64'd0);
        end
        if (line_err) begin
            nerr++;
            chk("err_with_done", 64'(line_done), 64'd1);
        end
        if (overrun) novr++;
        if (!psram_req) req_low++;
        else begin
            if (req_low > 0 && ncmd > 0 && ndone == 0) chk("req_gap", 64'(req_low), 64'd1);
            req_low = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_line(input int ln);
        @(negedge clk);
        cur_line = ln; nwr = 0; ncmd = 0; ndone = 0; nerr = 0; novr = 0; mcmd = 0;
        line_num = 10'(ln);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget, input bit ovr_at_done);
        int i;
        i = 0;
        while (!line_done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("line_done_seen", 64'(line_done), 64'd1);
        if (ovr_at_done && line_done) begin
            line_num = ~line_num;
            line_start = 1'b1;
            @(negedge clk);
            line_start = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cmds(input int n);
        int i;
        i = 0;
        while (ncmd < n && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("cmd_count_reached", 64'(ncmd >= n), 64'd1);
    endtask

    task automatic chk_line(input string tag, input int cmds, input int wrs, input int errs);
        chk({tag, "_done"}, 64'(ndone), 64'd1);
        chk({tag, "_err"}, 64'(nerr), 64'(errs));
        chk({tag, "_cmds"}, 64'(ncmd), 64'(cmds));
        chk({tag, "_writes"}, 64'(nwr), 64'(wrs));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int diffs, ln, saved;
        seed = {$urandom, $urandom};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, line_done, line_err, overrun, psram_req, cmd_en, lb_we, cmd}, 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_waddr", 64'(lb_waddr), 64'd0);
        chk("rst_wdata", lb_wdata, 64'd0);
        chk("rst_mask", 64'(data_mask), 64'd0);
        reset = 1'b0;

        // 1: line 5, immediate grant
        start_line(5);
        wait_done(3000, 1'b0);
        chk_line("s1", 64, 256, 0);
        for (int i = 0; i < 256; i++) ref_img[i] = lb_img[i];

        // spurious beats while IDLE
        nwr = 0;
        rd_data_valid = 1'b1;
        rd_data = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        rd_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_spurious_writes", 64'(nwr), 64'd0);

        // 2: same line, random grant delay 0..20; image must match scenario 1
        gnt_min = 0; gnt_max = 20;
        for (int i = 0; i < 256; i++) lb_img[i] = '0;
        start_line(5);
        wait_done(8000, 1'b0);
        chk_line("s2", 64, 256, 0);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (lb_img[i] !== ref_img[i]) diffs++;
        chk("s2_image", 64'(diffs), 64'd0);

        // spurious beat while waiting in REQ
        gnt_min = 6; gnt_max = 6;
        ln = $urandom_range(1023, 0);
        start_line(ln);
        @(negedge clk);
        rd_data_valid = 1'b1;
        rd_data = {$urandom, $urandom};
        @(negedge clk);
        rd_data_valid = 1'b0;
        wait_done(8000, 1'b0);
        chk_line("req_spur", 64, 256, 0);

        // 3: drop 3rd beat of block 10 -> timeout abort
        gnt_min = 0; gnt_max = 3;
        drop_blk = 10;
        ln = $urandom_range(1023, 0);
        start_line(ln);
        wait_done(5000, 1'b0);
        chk_line("drop", 11, 42, 1);
        chk("drop_latency", 64'(done_cyc - t2), 64'(TO));
        repeat (300) @(negedge clk);
        chk("drop_no_more_cmds", 64'(ncmd), 64'd11);
        chk("drop_no_more_writes", 64'(nwr), 64'd42);
        drop_blk = -1;

        // 4: line_start mid-fetch and in the line_done cycle -> overrun, fetch unchanged
        gnt_min = 0; gnt_max = 5;
        ln = $urandom_range(1023, 0);
        start_line(ln);
        wait_cmds(31);
        line_num = ~line_num;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("ovr_busy_kept", 64'(busy), 64'd1);
        wait_done(5000, 1'b1);
        chk_line("ovr", 64, 256, 0);
        chk("ovr_pulses", 64'(novr), 64'd2);

        // 5: reset during DATA of block 3, then fetch line 7
        gnt_min = 0; gnt_max = 0;
        ln = $urandom_range(1023, 0);
        start_line(ln);
        wait_cmds(4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        saved = nwr;
        repeat (20) @(negedge clk);
        chk("rst_mid_writes", 64'(nwr), 64'(saved));
        chk("rst_mid_blocks_written", 64'(saved), 64'd12);
        chk("rst_mid_no_done", 64'(ndone), 64'd0);
        chk("rst_mid_outs", {busy, psram_req, cmd_en, lb_we}, 64'd0);
        reset = 1'b0;
        start_line(7);
        wait_done(3000, 1'b0);
        chk_line("after_rst", 64, 256, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
